// File: rtl/pattern_serializer_fsm.sv
// Serial-pattern transmitter: latches a parallel pattern and shifts it out
// MSB-first for a programmed number of repetitions with an optional idle gap.
module pattern_serializer_fsm #(
    parameter int unsigned PAT_W = 4,
    parameter int unsigned CNT_W = 8,
    parameter int unsigned GAP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] reps,
    input  logic [GAP_W-1:0] gap,
    input  logic             abort,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sent_cnt,
    output logic [1:0]       state
);

    localparam int unsigned BIT_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [PAT_W-1:0]   pat_q, pat_d;
    logic [PAT_W-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]   reps_q, reps_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]   sent_q, sent_d;
    logic               ser_out_q, ser_out_d;
    logic               ser_valid_q, ser_valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // Next-state, datapath and registered-output computation
    always_comb begin
        state_d     = state_q;
        pat_d       = pat_q;
        shift_d     = shift_q;
        reps_d      = reps_q;
        gap_d       = gap_q;
        gap_cnt_d   = gap_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        sent_d      = sent_q;
        ser_out_d   = 1'b0;
        ser_valid_d = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    pat_d  = pattern;
                    reps_d = reps;
                    gap_d  = gap;
                    sent_d = '0;
                    if (reps != '0) begin
                        state_d     = S_SHIFT;
                        shift_d     = pattern;
                        bit_cnt_d   = '0;
                        ser_out_d   = pattern[PAT_W-1];
                        ser_valid_d = 1'b1;
                        busy_d      = 1'b1;
                    end else begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            S_SHIFT: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (bit_cnt_q == BIT_W'(PAT_W - 1)) begin
                    sent_d = CNT_W'(sent_q + CNT_W'(1));
                    // Widened compare so reps = all-ones terminates without wrap
                    if ((CNT_W+1)'(sent_q) + (CNT_W+1)'(1) == (CNT_W+1)'(reps_q)) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else if (gap_q == '0) begin
                        shift_d     = pat_q;
                        bit_cnt_d   = '0;
                        ser_out_d   = pat_q[PAT_W-1];
                        ser_valid_d = 1'b1;
                        busy_d      = 1'b1;
                    end else begin
                        state_d   = S_GAP;
                        gap_cnt_d = '0;
                        busy_d    = 1'b1;
                    end
                end else begin
                    shift_d     = {shift_q[PAT_W-2:0], 1'b0};
                    bit_cnt_d   = BIT_W'(bit_cnt_q + BIT_W'(1));
                    ser_out_d   = shift_q[PAT_W-2];
                    ser_valid_d = 1'b1;
                    busy_d      = 1'b1;
                end
            end
            S_GAP: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (gap_cnt_q == GAP_W'(gap_q - GAP_W'(1))) begin
                    state_d     = S_SHIFT;
                    shift_d     = pat_q;
                    bit_cnt_d   = '0;
                    ser_out_d   = pat_q[PAT_W-1];
                    ser_valid_d = 1'b1;
                    busy_d      = 1'b1;
                end else begin
                    gap_cnt_d = GAP_W'(gap_cnt_q + GAP_W'(1));
                    busy_d    = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pat_q       <= '0;
            shift_q     <= '0;
            reps_q      <= '0;
            gap_q       <= '0;
            gap_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            sent_q      <= '0;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pat_q       <= pat_d;
            shift_q     <= shift_d;
            reps_q      <= reps_d;
            gap_q       <= gap_d;
            gap_cnt_q   <= gap_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            sent_q      <= sent_d;
            ser_out_q   <= ser_out_d;
            ser_valid_q <= ser_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign ser_out   = ser_out_q;
    assign ser_valid = ser_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign sent_cnt  = sent_q;
    assign state     = state_q;

endmodule
